// File: rtl/stdp_pkg.sv
// Shared constants and arithmetic helpers for the STDP synapse and its trace registers.
// Helpers are sized for the default weight width; the signed delta width leaves room for sign and overflow.
package stdp_pkg;

   localparam int W_WIDTH_DEF  = 8;
   localparam int DELTA_WIDTH  = W_WIDTH_DEF + 2;

   function automatic logic [W_WIDTH_DEF-1:0] sat_add_u(
      input logic [W_WIDTH_DEF-1:0] a,
      input logic [W_WIDTH_DEF-1:0] b
   );
      logic [W_WIDTH_DEF:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[W_WIDTH_DEF]) begin
         return '1;
      end
      return sum[W_WIDTH_DEF-1:0];
   endfunction

   function automatic logic [W_WIDTH_DEF-1:0] clamp_w(
      input logic signed [DELTA_WIDTH-1:0] value,
      input logic        [W_WIDTH_DEF-1:0] lo,
      input logic        [W_WIDTH_DEF-1:0] hi
   );
      logic signed [DELTA_WIDTH-1:0] lo_s;
      logic signed [DELTA_WIDTH-1:0] hi_s;
      lo_s = $signed({2'b00, lo});
      hi_s = $signed({2'b00, hi});
      if (value < lo_s) begin
         return lo;
      end
      if (value > hi_s) begin
         return hi;
      end
      return value[W_WIDTH_DEF-1:0];
   endfunction

   // Geometric decay; small values stall once (value >> shift) reaches zero.
   function automatic logic [W_WIDTH_DEF-1:0] decay(
      input logic [W_WIDTH_DEF-1:0] value,
      input int                     shift
   );
      return value - (value >> shift);
   endfunction

endpackage

// File: rtl/stdp_trace.sv
// One STDP eligibility trace: a spike sets (or, with STDP_ALL_TO_ALL_EN, saturating-adds) TRACE_INC,
// a decay tick without a spike shrinks the trace geometrically, otherwise it holds.
module stdp_trace
   import stdp_pkg::*;
#(
   parameter int                 W_WIDTH     = W_WIDTH_DEF,
   parameter logic [W_WIDTH-1:0] TRACE_INC   = 8'd128,
   parameter int                 TRACE_SHIFT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spike,
   input  logic               tick,
   output logic [W_WIDTH-1:0] trace_out
);

   logic [W_WIDTH-1:0] trace_q;
   logic [W_WIDTH-1:0] trace_d;

   // A spike outranks a decay tick landing in the same cycle.
   always_comb begin
      trace_d = trace_q;
      if (spike) begin
`ifdef STDP_ALL_TO_ALL_EN
         trace_d = sat_add_u(trace_q, TRACE_INC);
`else
         trace_d = TRACE_INC;
`endif
      end else if (tick) begin
         trace_d = decay(trace_q, TRACE_SHIFT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trace_q <= '0;
      end else begin
         trace_q <= trace_d;
      end
   end

   assign trace_out = trace_q;

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: turns presynaptic spikes into a decaying current and adapts its weight by pair-based STDP.
// Build option STDP_ALL_TO_ALL_EN switches the traces from nearest-neighbour to all-to-all pairing.
module stdp_synapse
   import stdp_pkg::*;
#(
   parameter int                 W_WIDTH      = W_WIDTH_DEF,
   parameter logic [W_WIDTH-1:0] W_INIT       = 8'd64,
   parameter logic [W_WIDTH-1:0] W_MIN        = 8'd0,
   parameter logic [W_WIDTH-1:0] W_MAX        = 8'd255,
   parameter logic [W_WIDTH-1:0] TRACE_INC    = 8'd128,
   parameter int                 TRACE_SHIFT  = 2,
   parameter int                 CUR_SHIFT    = 1,
   parameter int                 LR_SHIFT     = 3,
   parameter int                 DECAY_PERIOD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pre_spike,
   input  logic               post_spike,
   input  logic               learn_en,
   output logic [W_WIDTH-1:0] current,
   output logic [W_WIDTH-1:0] weight,
   output logic               update_valid
);

   localparam int CNT_W = $clog2(DECAY_PERIOD);

   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               tick;

   logic [W_WIDTH-1:0] weight_q;
   logic [W_WIDTH-1:0] weight_d;
   logic [W_WIDTH-1:0] current_q;
   logic [W_WIDTH-1:0] current_d;
   logic               update_valid_q;
   logic               update_valid_d;

   logic [W_WIDTH-1:0] pre_trace;
   logic [W_WIDTH-1:0] post_trace;
   logic [W_WIDTH-1:0] pre_lr;
   logic [W_WIDTH-1:0] post_lr;

   logic signed [DELTA_WIDTH-1:0] potentiation;
   logic signed [DELTA_WIDTH-1:0] depression;
   logic signed [DELTA_WIDTH-1:0] weight_sum;
   logic [W_WIDTH-1:0]            weight_new;

   always_comb begin
      tick  = (cnt_q == CNT_W'(DECAY_PERIOD - 1));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   stdp_trace #(
      .W_WIDTH     (W_WIDTH),
      .TRACE_INC   (TRACE_INC),
      .TRACE_SHIFT (TRACE_SHIFT)
   ) u_pre_trace (
      .clk       (clk),
      .rst       (rst),
      .spike     (pre_spike),
      .tick      (tick),
      .trace_out (pre_trace)
   );

   stdp_trace #(
      .W_WIDTH     (W_WIDTH),
      .TRACE_INC   (TRACE_INC),
      .TRACE_SHIFT (TRACE_SHIFT)
   ) u_post_trace (
      .clk       (clk),
      .rst       (rst),
      .spike     (post_spike),
      .tick      (tick),
      .trace_out (post_trace)
   );

   // Pre-update trace values drive the delta; post_spike potentiates, pre_spike depresses.
   always_comb begin
      pre_lr       = pre_trace >> LR_SHIFT;
      post_lr      = post_trace >> LR_SHIFT;
      potentiation = post_spike ? $signed({2'b00, pre_lr})  : '0;
      depression   = pre_spike  ? $signed({2'b00, post_lr}) : '0;
      weight_sum   = $signed({2'b00, weight_q}) + potentiation - depression;
      weight_new   = clamp_w(weight_sum, W_MIN, W_MAX);
   end

   // A clamped update that leaves the weight where it was must not raise update_valid.
   always_comb begin
      weight_d       = weight_q;
      update_valid_d = 1'b0;
      if (learn_en && (pre_spike || post_spike) && (weight_new != weight_q)) begin
         weight_d       = weight_new;
         update_valid_d = 1'b1;
      end
   end

   always_comb begin
      current_d = current_q;
      if (pre_spike) begin
         current_d = sat_add_u(current_q, weight_q);
      end else if (tick) begin
         current_d = decay(current_q, CUR_SHIFT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         weight_q       <= W_INIT;
         current_q      <= '0;
         update_valid_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         weight_q       <= weight_d;
         current_q      <= current_d;
         update_valid_q <= update_valid_d;
      end
   end

   assign current      = current_q;
   assign weight       = weight_q;
   assign update_valid = update_valid_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Scoreboard bench for stdp_synapse: a cycle model pushes expected outputs per driven vector,
// which are popped and compared one edge later; directed checks pin the key scenario values.
module tb_stdp_synapse;

   logic       clk;
   logic       rst;
   logic       pre_spike;
   logic       post_spike;
   logic       learn_en;
   logic [7:0] current;
   logic [7:0] weight;
   logic       update_valid;

   typedef struct {
      int w;
      int cur;
      int uv;
      int pt;
      int qt;
   } exp_t;

   exp_t sbQueue[$];

   int vectorCount = 0;
   int missCount   = 0;

   int mCnt;
   int mW;
   int mCur;
   int mPt;
   int mQt;

   stdp_synapse dut (
      .clk          (clk),
      .rst          (rst),
      .pre_spike    (pre_spike),
      .post_spike   (post_spike),
      .learn_en     (learn_en),
      .current      (current),
      .weight       (weight),
      .update_valid (update_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guards against a stalled run; should never fire.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int nextTrace(input int old, input bit spike, input bit tick);
`ifdef STDP_ALL_TO_ALL_EN
      if (spike) return (old + 128 > 255) ? 255 : old + 128;
`else
      if (spike) return 128;
`endif
      if (tick) return old - old / 4;
      return old;
   endfunction

   // Cycle model of the synapse; pushes the expected post-edge state onto the scoreboard.
   task automatic modelStep(input bit p, input bit q, input bit l);
      exp_t e;
      bit   tick;
      int   nw;
      tick = (mCnt == 3);
      nw   = mW;
      if (l && q) nw = nw + mPt / 8;
      if (l && p) nw = nw - mQt / 8;
      if (nw < 0)   nw = 0;
      if (nw > 255) nw = 255;
      e.uv = (nw != mW) ? 1 : 0;
      if (p)         e.cur = (mCur + mW > 255) ? 255 : mCur + mW;
      else if (tick) e.cur = mCur - mCur / 2;
      else           e.cur = mCur;
      e.pt = nextTrace(mPt, p, tick);
      e.qt = nextTrace(mQt, q, tick);
      e.w  = nw;
      mW   = e.w;
      mCur = e.cur;
      mPt  = e.pt;
      mQt  = e.qt;
      mCnt = (mCnt + 1) % 4;
      sbQueue.push_back(e);
   endtask

   task automatic applyStimulus(input bit p, input bit q, input bit l);
      exp_t e;
      @(negedge clk);
      rst        = 1'b0;
      pre_spike  = p;
      post_spike = q;
      learn_en   = l;
      modelStep(p, q, l);
      @(posedge clk);
      #1;
      e = sbQueue.pop_front();
      checkOutput("sb_weight",       16'(weight),               16'(e.w));
      checkOutput("sb_current",      16'(current),              16'(e.cur));
      checkOutput("sb_update_valid", 16'(update_valid),         16'(e.uv));
      checkOutput("sb_pre_trace",    16'(dut.pre_trace),        16'(e.pt));
      checkOutput("sb_post_trace",   16'(dut.post_trace),       16'(e.qt));
   endtask

   // Holds rst for two edges and leaves it asserted; the next applied vector releases it.
   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      pre_spike  = 1'b0;
      post_spike = 1'b0;
      learn_en   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_weight",       16'(weight),         16'd64);
      checkOutput("rst_current",      16'(current),        16'd0);
      checkOutput("rst_update_valid", 16'(update_valid),   16'd0);
      checkOutput("rst_pre_trace",    16'(dut.pre_trace),  16'd0);
      checkOutput("rst_post_trace",   16'(dut.post_trace), 16'd0);
      mCnt = 0;
      mW   = 64;
      mCur = 0;
      mPt  = 0;
      mQt  = 0;
   endtask

   initial begin
      rst        = 1'b1;
      pre_spike  = 1'b0;
      post_spike = 1'b0;
      learn_en   = 1'b0;

      // Causal pair
      doReset();
      applyStimulus(1, 0, 1);
      checkOutput("causal_c1_weight",  16'(weight),       16'd64);
      checkOutput("causal_c1_uv",      16'(update_valid), 16'd0);
      checkOutput("causal_c1_current", 16'(current),      16'd64);
      applyStimulus(0, 1, 1);
      checkOutput("causal_c2_weight",  16'(weight),       16'd80);
      checkOutput("causal_c2_uv",      16'(update_valid), 16'd1);
      applyStimulus(0, 0, 1);
      checkOutput("causal_c3_uv",      16'(update_valid), 16'd0);

      // Anti-causal pair
      doReset();
      applyStimulus(0, 1, 1);
      applyStimulus(1, 0, 1);
      checkOutput("anti_weight",  16'(weight),       16'd48);
      checkOutput("anti_uv",      16'(update_valid), 16'd1);
      checkOutput("anti_current", 16'(current),      16'd64);

      // Back-to-back pre spikes saturate the current, then one decay tick
      doReset();
      applyStimulus(1, 0, 1);
      checkOutput("b2b_cur1", 16'(current), 16'd64);
      applyStimulus(1, 0, 1);
      checkOutput("b2b_cur2", 16'(current), 16'd128);
      applyStimulus(1, 0, 1);
      checkOutput("b2b_cur3", 16'(current), 16'd192);
      applyStimulus(1, 0, 1);
      checkOutput("b2b_cur4", 16'(current), 16'd255);
      repeat (3) applyStimulus(0, 0, 1);
      checkOutput("cur_hold", 16'(current), 16'd255);
      applyStimulus(0, 0, 1);
      checkOutput("cur_decay", 16'(current), 16'd128);

      // Simultaneous pre+post with empty traces, then a trace decay tick
      doReset();
      applyStimulus(1, 1, 1);
      checkOutput("sim_weight",   16'(weight),          16'd64);
      checkOutput("sim_uv",       16'(update_valid),    16'd0);
      checkOutput("sim_pre_tr",   16'(dut.pre_trace),   16'd128);
      checkOutput("sim_post_tr",  16'(dut.post_trace),  16'd128);
      repeat (3) applyStimulus(0, 0, 1);
      checkOutput("sim_pre_decay",  16'(dut.pre_trace),  16'd96);
      checkOutput("sim_post_decay", 16'(dut.post_trace), 16'd96);

      // Learning disabled
      doReset();
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("nolearn_weight", 16'(weight),       16'd64);
      checkOutput("nolearn_uv",     16'(update_valid), 16'd0);
      checkOutput("nolearn_cur",    16'(current),      16'd64);

      // Weight saturation: potentiate only on post (pre cycles have learning off)
      doReset();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, 0, 0);
         applyStimulus(0, 1, 1);
      end
      checkOutput("sat_w240", 16'(weight), 16'd240);
      applyStimulus(1, 0, 0);
      repeat (4) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 1);
      checkOutput("sat_w252", 16'(weight), 16'd252);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1);
      checkOutput("sat_w255",    16'(weight),       16'd255);
      checkOutput("sat_uv_hit",  16'(update_valid), 16'd1);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1);
      checkOutput("sat_w_hold",  16'(weight),       16'd255);
      checkOutput("sat_uv_none", 16'(update_valid), 16'd0);

      // Consecutive pre spikes: all-to-all accumulates, nearest-neighbour resets
      doReset();
      applyStimulus(1, 0, 1);
      checkOutput("pair_tr1", 16'(dut.pre_trace), 16'd128);
      applyStimulus(1, 0, 1);
`ifdef STDP_ALL_TO_ALL_EN
      checkOutput("pair_tr2", 16'(dut.pre_trace), 16'd255);
`else
      checkOutput("pair_tr2", 16'(dut.pre_trace), 16'd128);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
